// File: rtl/vending_pkg.sv
// Shared types and elaboration helpers for the parametrised vending controller.
// Also consumed by the VEND_CANCEL_EN refund build; nothing here depends on it.
package vending_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        DISPENSE = 2'd2,
        REFUND   = 2'd3
    } vend_state_e;

    localparam int VEND_CW     = 8;
    localparam int TBL_MAX_W   = 1024;
    localparam int SLICE_MAX_W = 32;
    localparam int SEL_MAX_W   = 64;

    // Tables are zero-extended to TBL_MAX_W by the caller so one function serves every size.
    function automatic logic [SLICE_MAX_W-1:0] tbl_slice(input logic [TBL_MAX_W-1:0] tbl,
                                                         input int unsigned idx,
                                                         input int unsigned w);
        logic [TBL_MAX_W-1:0] sh;
        sh = tbl >> (idx * w);
        tbl_slice = '0;
        for (int b = 0; b < SLICE_MAX_W; b++)
            if (b < int'(w)) tbl_slice[b] = sh[b];
    endfunction

    function automatic logic [5:0] oh2idx(input logic [SEL_MAX_W-1:0] oh);
        oh2idx = '0;
        for (int i = SEL_MAX_W-1; i >= 0; i--)
            if (oh[i]) oh2idx = 6'(i);
    endfunction

endpackage

// File: rtl/vending_ctrl_param_if.sv
// User-facing bundle of the vending controller: buttons in, dispense/change/status out.
// cancel only has an effect when the block is built with VEND_CANCEL_EN.
interface vending_ctrl_param_if
    import vending_pkg::*;
#(
    parameter int N_PROD = 4,
    parameter int N_COIN = 3,
    parameter int CW     = VEND_CW
);
    logic [N_PROD-1:0] sel;
    logic [N_COIN-1:0] coin;
    logic              cancel;
    logic [N_PROD-1:0] dispense;
    logic [CW-1:0]     change;
    logic              change_valid;
    logic              busy;
    logic [CW-1:0]     credit;

    modport master (
        output sel, coin, cancel,
        input  dispense, change, change_valid, busy, credit
    );

    modport slave (
        input  sel, coin, cancel,
        output dispense, change, change_valid, busy, credit
    );
endinterface

// File: rtl/vend_hold_timer.sv
// Down-counter shared by the dispense and refund holds: start loads HOLD_CYC,
// done flags the last held cycle. The counter parks at zero and never wraps.
module vend_hold_timer #(
    parameter int HOLD_CYC = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    output logic done
);
    localparam int CNT_W = $clog2(HOLD_CYC + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (!reset)
            cnt <= '0;
        else if (start)
            cnt <= CNT_W'(HOLD_CYC);
        else if (cnt != '0)
            cnt <= cnt - CNT_W'(1);
    end

    assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/vending_ctrl_param.sv
// Parametrised vending controller: product select, coin credit, dispense/change hold.
// Define VEND_CANCEL_EN to add the cancel/refund path (REFUND state).
module vending_ctrl_param
    import vending_pkg::*;
#(
    parameter int                   N_PROD    = 4,
    parameter int                   N_COIN    = 3,
    parameter int                   CW        = VEND_CW,
    parameter logic [N_PROD*CW-1:0] PRICES    = {8'd4, 8'd3, 8'd2, 8'd1},
    parameter logic [N_COIN*CW-1:0] COIN_VALS = {8'd5, 8'd2, 8'd1},
    parameter int                   HOLD_CYC  = 10
) (
    input logic                clock,
    input logic                reset,
    vending_ctrl_param_if.slave bus
);
    localparam int IDX_W  = (N_PROD > 1) ? $clog2(N_PROD) : 1;
    localparam int CIDX_W = (N_COIN > 1) ? $clog2(N_COIN) : 1;

    localparam logic [1:0] S_IDLE     = 2'(IDLE);
    localparam logic [1:0] S_COLLECT  = 2'(COLLECT);
    localparam logic [1:0] S_DISPENSE = 2'(DISPENSE);
    localparam logic [1:0] S_REFUND   = 2'(REFUND);

    logic [CW-1:0]     price_tbl [N_PROD];
    logic [CW-1:0]     coin_tbl  [N_COIN];

    logic [1:0]        state;
    logic [IDX_W-1:0]  idx;
    logic [CW-1:0]     credit;
    logic [CW-1:0]     change;
    logic              change_valid;
    logic [N_PROD-1:0] dispense;
    logic [N_COIN-1:0] prev_coin;

    logic [N_COIN-1:0] rise;
    logic              rise_any;
    logic [CIDX_W-1:0] rise_idx;
    logic [CW:0]       credit_sum;
    logic [CW-1:0]     credit_sat;
    logic              sel_onehot;
    logic              paid;
    logic              hold_start;
    logic              hold_done;

    for (genvar i = 0; i < N_PROD; i++) begin : g_price
        assign price_tbl[i] = CW'(tbl_slice(TBL_MAX_W'(PRICES), i, CW));
    end

    for (genvar i = 0; i < N_COIN; i++) begin : g_coin
        assign coin_tbl[i] = CW'(tbl_slice(TBL_MAX_W'(COIN_VALS), i, CW));
    end

    // Lowest-index rising coin wins; simultaneous higher-index rises are dropped.
    always_comb begin
        rise     = bus.coin & ~prev_coin;
        rise_any = |rise;
        rise_idx = '0;
        for (int i = N_COIN-1; i >= 0; i--)
            if (rise[i]) rise_idx = CIDX_W'(i);
        credit_sum = {1'b0, credit} + {1'b0, coin_tbl[rise_idx]};
        credit_sat = credit_sum[CW] ? '1 : credit_sum[CW-1:0];
        sel_onehot = (bus.sel != '0) && ((bus.sel & (bus.sel - N_PROD'(1))) == '0);
        paid       = (credit >= price_tbl[idx]);
    end

    always_comb begin
        hold_start = 1'b0;
        if (state == S_COLLECT) begin
`ifdef VEND_CANCEL_EN
            hold_start = bus.cancel | paid;
`else
            hold_start = paid;
`endif
        end
    end

`ifndef VEND_CANCEL_EN
    logic unused_cancel;
    assign unused_cancel = bus.cancel;
`endif

    vend_hold_timer #(
        .HOLD_CYC (HOLD_CYC)
    ) u_hold (
        .clock (clock),
        .reset (reset),
        .start (hold_start),
        .done  (hold_done)
    );

    // prev_coin loads even under reset so a button held through reset is not seen as a press.
    always_ff @(posedge clock) begin
        prev_coin <= bus.coin;
        if (!reset) begin
            state        <= S_IDLE;
            idx          <= '0;
            credit       <= '0;
            change       <= '0;
            change_valid <= 1'b0;
            dispense     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (sel_onehot) begin
                        idx   <= IDX_W'(oh2idx(SEL_MAX_W'(bus.sel)));
                        state <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
`ifdef VEND_CANCEL_EN
                    if (bus.cancel) begin
                        state        <= S_REFUND;
                        change       <= credit;
                        change_valid <= 1'b1;
                    end else
`endif
                    if (paid) begin
                        state        <= S_DISPENSE;
                        change       <= credit - price_tbl[idx];
                        change_valid <= 1'b1;
                        dispense     <= N_PROD'(1) << idx;
                    end else if (rise_any) begin
                        credit <= credit_sat;
                    end
                end
`ifdef VEND_CANCEL_EN
                S_DISPENSE, S_REFUND: begin
`else
                S_DISPENSE: begin
`endif
                    if (hold_done) begin
                        state        <= S_IDLE;
                        credit       <= '0;
                        change       <= '0;
                        change_valid <= 1'b0;
                        dispense     <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.dispense     = dispense;
    assign bus.change       = change;
    assign bus.change_valid = change_valid;
    assign bus.busy         = (state != S_IDLE);
    assign bus.credit       = credit;

endmodule
